oam_dma: RTL
============

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'h4014, CPU address whose write starts a transfer.
REQ-002 Parameter OAM_DATA_ADDR, default 16'h2004, destination address of every DMA write.
REQ-003 Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 CPU_CE  input  1  one-Clk strobe marking the end of each CPU bus cycle.
REQ-006 CPU_ADDR  input  16  CPU address.
REQ-007 CPU_WR  input  1  CPU read/write strobe: 1 = read, 0 = write.
REQ-008 CPU_DO  input  8  CPU write data.
REQ-009 DMA_DI  input  8  decoded bus read data returned to the DMA.
REQ-010 CPU_RDY  output  1  0 halts the CPU.
REQ-011 BUS_SEL  output  1  1 = DMA drives address, data and read/write onto the bus.
REQ-012 DMA_ADDR  output  16  DMA bus address.
REQ-013 DMA_WR  output  1  DMA read/write strobe, same polarity as CPU_WR.
REQ-014 DMA_DO  output  8  DMA write data.

Function
REQ-015 States: IDLE, HALT, ALIGN, READ, WRITE; the state advances only on Clk edges where CPU_CE=1.
REQ-016 IDLE: CPU_CE=1, CPU_WR=0 and CPU_ADDR==DMA_REG_ADDR latch CPU_DO as page, clear the 8-bit index, clear CPU_RDY on the same edge, go to HALT.
REQ-017 HALT lasts one CE cycle (the CPU finishes its write); BUS_SEL=0 throughout.
REQ-018 Parity bit toggles on every CPU_CE edge in every state; at the CE that ends HALT, parity=1 goes to ALIGN, parity=0 goes to READ.
REQ-019 ALIGN lasts one CE cycle with BUS_SEL=1, DMA_WR=1, and DMA_ADDR unchanged from its previous value; then go to READ.
REQ-020 READ: BUS_SEL=1, DMA_WR=1, DMA_ADDR={page,index}; on CE, register DMA_DI into the data register, go to WRITE.
REQ-021 WRITE: BUS_SEL=1, DMA_WR=0, DMA_ADDR=OAM_DATA_ADDR, DMA_DO=data register; on CE, index==8'hFF goes to IDLE, otherwise increment index and go to READ.
REQ-022 On the edge leaving WRITE for IDLE, set CPU_RDY=1 and BUS_SEL=0.
REQ-023 Transfer length is exactly 256 read/write pairs; the index is 8 bits and never carries into the page.
REQ-024 Total halt is 513 CE cycles, or 514 when ALIGN is inserted.
REQ-025 Triggers outside IDLE are ignored.
REQ-026 Page 8'hFF is legal; the last read is 16'hFFFF.
REQ-027 Clk edges without CPU_CE hold all state and outputs.
REQ-028 All outputs are registered.

Reset
REQ-029 Reset takes priority over all other inputs and may occur in any state.
REQ-030 Reset values: state IDLE, CPU_RDY=1, BUS_SEL=0, DMA_ADDR=0, DMA_WR=1, DMA_DO=0, page=0, index=0, parity=0.
REQ-031 Reset mid-transfer abandons the transfer; no further DMA bus cycles occur.

Configuration
REQ-032 Macro OAM_DMA_ALIGN_EN: when defined, ALIGN behaves as in REQ-018/019.
REQ-033 Without OAM_DMA_ALIGN_EN, HALT always goes to READ, every transfer is 513 CE cycles, and the parity bit is not implemented.

Structure
REQ-034 The shared package naes_bus_pkg holds the state enum type, the 16'h4014 and 16'h2004 address constants, and the read/write polarity constants.
REQ-035 No sub-module: the index counter and the FSM stay in oam_dma.

Verification
REQ-036 Reset, then write 8'h02 to 16'h4014 with parity=0: 256 reads 16'h0200..16'h02FF alternate with writes to 16'h2004, and CPU_RDY stays low for 513 CE cycles.
REQ-037 Same as REQ-036 but triggered with parity=1: 514 CE cycles and exactly one ALIGN cycle; without the macro, 513 cycles.
REQ-038 Bus model with DMA_DI = low address byte, page 8'h07: DMA_DO sequence is 8'h00..8'hFF in order.
REQ-039 Page 8'hFF: last read at 16'hFFFF, return to IDLE, and no access to 16'h0000.
REQ-040 Assert Reset during the 100th read: the next edge gives CPU_RDY=1 and BUS_SEL=0; a new trigger then runs a full transfer.
REQ-041 CPU_CE held low for 10 Clk mid-transfer: outputs frozen; a read at 16'h4014 (CPU_WR=1) in IDLE does not trigger.

Source files
------------

// File: rtl/naes_bus_pkg.sv
// Shared bus definitions for the NAES CPU-side DMA blocks: DMA state encoding,
// fixed register addresses and read/write strobe polarity.
package naes_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

endpackage

// File: rtl/oam_dma.sv
// Sprite-memory DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies one
// 256-byte page to OAM_DATA_ADDR. Define OAM_DMA_ALIGN_EN for the odd-cycle ALIGN slot.
module oam_dma
  import naes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CPU_CE,
  input  logic [15:0] CPU_ADDR,
  input  logic        CPU_WR,
  input  logic [7:0]  CPU_DO,
  input  logic [7:0]  DMA_DI,
  output logic        CPU_RDY,
  output logic        BUS_SEL,
  output logic [15:0] DMA_ADDR,
  output logic        DMA_WR,
  output logic [7:0]  DMA_DO
);

  dma_state_t  state, state_next;
  logic [7:0]  page, page_next;
  logic [7:0]  index, index_next;
  logic        rdy_next, sel_next, wr_next;
  logic [15:0] addr_next;
  logic [7:0]  do_next;
  logic        trigger;

`ifdef OAM_DMA_ALIGN_EN
  logic parity;
`endif

  assign trigger = (CPU_WR == BUS_WRITE) && (CPU_ADDR == DMA_REG_ADDR);

  // State register; every output is a flop so the bus sees clean levels.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      page     <= 8'h00;
      index    <= 8'h00;
      CPU_RDY  <= 1'b1;
      BUS_SEL  <= 1'b0;
      DMA_ADDR <= 16'h0000;
      DMA_WR   <= BUS_READ;
      DMA_DO   <= 8'h00;
    end else if (CPU_CE) begin
      state    <= state_next;
      page     <= page_next;
      index    <= index_next;
      CPU_RDY  <= rdy_next;
      BUS_SEL  <= sel_next;
      DMA_ADDR <= addr_next;
      DMA_WR   <= wr_next;
      DMA_DO   <= do_next;
    end
  end

`ifdef OAM_DMA_ALIGN_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      parity <= 1'b0;
    end else if (CPU_CE) begin
      parity <= ~parity;
    end
  end
`endif

  always_comb begin
    state_next = state;
    page_next  = page;
    index_next = index;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          page_next  = CPU_DO;
          index_next = 8'h00;
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        state_next = parity ? ST_ALIGN : ST_READ;
`else
        state_next = ST_READ;
`endif
      end
      ST_ALIGN: state_next = ST_READ;
      ST_READ:  state_next = ST_WRITE;
      ST_WRITE: begin
        if (index == 8'hFF) begin
          state_next = ST_IDLE;
        end else begin
          index_next = index + 8'd1;
          state_next = ST_READ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered, then registered above.
  always_comb begin
    rdy_next  = CPU_RDY;
    sel_next  = BUS_SEL;
    addr_next = DMA_ADDR;
    wr_next   = DMA_WR;
    do_next   = (state == ST_READ) ? DMA_DI : DMA_DO;
    case (state_next)
      ST_IDLE: begin
        rdy_next = 1'b1;
        sel_next = 1'b0;
        wr_next  = BUS_READ;
      end
      ST_HALT: begin
        rdy_next = 1'b0;
        sel_next = 1'b0;
      end
      ST_ALIGN: begin
        sel_next = 1'b1;
        wr_next  = BUS_READ;
      end
      ST_READ: begin
        sel_next  = 1'b1;
        wr_next   = BUS_READ;
        addr_next = {page_next, index_next};
      end
      ST_WRITE: begin
        sel_next  = 1'b1;
        wr_next   = BUS_WRITE;
        addr_next = OAM_DATA_ADDR;
      end
      default: begin
        rdy_next = 1'b1;
        sel_next = 1'b0;
      end
    endcase
  end

endmodule
